conv_addr_seq: RTL

- Parametrised successor of the conv1d memory-pointer block.
- Autonomous address sequencer: on `start`, emits the complete read/write address stream for one 1-D convolution pass.
- Per output element it emits interleaved kernel/input read addresses, then one output write address.
- Sits between the conv1d control unit and the shared memory port. The stream is valid/ready handshaked, so memory back-pressure stalls it cleanly.

---
 rtl/conv_pkg.sv | 28 ++
 rtl/conv_addr_seq_counter.sv | 46 ++++
 rtl/conv_addr_seq.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types and defaults for the 1-D convolution address sequencer.
package conv_pkg;

    typedef enum logic [1:0] {
        AK_KER = 2'b00,
        AK_INP = 2'b01,
        AK_OUT = 2'b10
    } addr_kind_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KER,
        ST_INP,
        ST_OUT,
        ST_FIN
    } conv_seq_state_e;

    localparam int unsigned DEF_KER_LEN  = 20;
    localparam int unsigned DEF_INP_BASE = 20;
    localparam int unsigned DEF_OUT_BASE = 108;
    localparam int unsigned DEF_N_OUT    = 20;

    // Bits needed to count 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_addr_seq_counter.sv
// tc_counter: up-counter with sync clear/load/enable and a registered terminal-count flag.
module tc_counter #(
    parameter int unsigned MAX_VAL = 1,
    parameter int unsigned CNT_W   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic [CNT_W-1:0] cnt_nxt_c,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tc_q;
    logic             tc_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        tc_d = (cnt_d == CNT_W'(MAX_VAL));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            tc_q  <= (MAX_VAL == 0);
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
        end
    end

    assign cnt_nxt_c = cnt_d;
    assign tc        = tc_q;

endmodule

// File: rtl/conv_addr_seq.sv
// Address sequencer for one 1-D convolution pass: interleaved kernel/input reads, then an output write.
// Optional macro CONV_ADDR_SEQ_DILATION_EN adds parameter DILATION (input step within a window).
module conv_addr_seq
    import conv_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned KER_BASE = 0,
    parameter int unsigned KER_LEN  = DEF_KER_LEN,
    parameter int unsigned INP_BASE = DEF_INP_BASE,
    parameter int unsigned OUT_BASE = DEF_OUT_BASE,
    parameter int unsigned N_OUT    = DEF_N_OUT,
    parameter int unsigned STRIDE   = 1
`ifdef CONV_ADDR_SEQ_DILATION_EN
    ,
    parameter int unsigned DILATION = 1
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              addr_ready,
    output logic              addr_valid,
    output logic [ADDR_W-1:0] addr,
    output logic [1:0]        addr_kind,
    output logic              ker_last,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

`ifdef CONV_ADDR_SEQ_DILATION_EN
    localparam int unsigned INP_STEP = DILATION;
`else
    localparam int unsigned INP_STEP = 1;
`endif
    localparam int unsigned K_W = cnt_w(KER_LEN);
    localparam int unsigned O_W = cnt_w(N_OUT);

    conv_seq_state_e   state_q, state_d;
    logic [ADDR_W-1:0] win_base_q, win_base_d;
    logic [ADDR_W-1:0] inp_ptr_q, inp_ptr_d;

    logic              addr_valid_q, addr_valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    addr_kind_e        addr_kind_q, addr_kind_d;
    logic              ker_last_q, ker_last_d;
    logic              out_last_q, out_last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              accept;
    logic              k_clr, k_en, k_tc;
    logic              o_clr, o_en, o_tc;
    logic [K_W-1:0]    k_nxt_c;
    logic [O_W-1:0]    o_nxt_c;

    assign accept = addr_valid_q && addr_ready;

    tc_counter #(
        .MAX_VAL (KER_LEN - 1),
        .CNT_W   (K_W)
    ) u_k_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr       (k_clr),
        .load      (1'b0),
        .load_val  ('0),
        .en        (k_en),
        .cnt_nxt_c (k_nxt_c),
        .tc        (k_tc)
    );

    tc_counter #(
        .MAX_VAL (N_OUT - 1),
        .CNT_W   (O_W)
    ) u_o_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr       (o_clr),
        .load      (1'b0),
        .load_val  ('0),
        .en        (o_en),
        .cnt_nxt_c (o_nxt_c),
        .tc        (o_tc)
    );

    // Next state and pointer/counter control; nothing advances without an accept.
    always_comb begin
        state_d    = state_q;
        win_base_d = win_base_q;
        inp_ptr_d  = inp_ptr_q;
        k_clr      = 1'b0;
        k_en       = 1'b0;
        o_clr      = 1'b0;
        o_en       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_KER;
                    k_clr      = 1'b1;
                    o_clr      = 1'b1;
                    win_base_d = '0;
                    inp_ptr_d  = ADDR_W'(INP_BASE);
                end
            end
            ST_KER: begin
                if (accept) begin
                    state_d = ST_INP;
                end
            end
            ST_INP: begin
                if (accept) begin
                    if (!k_tc) begin
                        k_en      = 1'b1;
                        inp_ptr_d = inp_ptr_q + ADDR_W'(INP_STEP);
                        state_d   = ST_KER;
                    end else begin
                        state_d = ST_OUT;
                    end
                end
            end
            ST_OUT: begin
                if (accept) begin
                    if (!o_tc) begin
                        o_en       = 1'b1;
                        k_clr      = 1'b1;
                        win_base_d = win_base_q + ADDR_W'(STRIDE);
                        inp_ptr_d  = ADDR_W'(INP_BASE) + win_base_d;
                        state_d    = ST_KER;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Beat payload for the upcoming cycle; recomputes identically while stalled.
    always_comb begin
        addr_valid_d = 1'b0;
        addr_d       = '0;
        addr_kind_d  = AK_KER;
        ker_last_d   = 1'b0;
        out_last_d   = 1'b0;
        busy_d       = (state_d != ST_IDLE);
        done_d       = (state_d == ST_FIN);
        case (state_d)
            ST_KER: begin
                addr_valid_d = 1'b1;
                addr_d       = ADDR_W'(KER_BASE) + ADDR_W'(k_nxt_c);
                addr_kind_d  = AK_KER;
                ker_last_d   = (k_nxt_c == K_W'(KER_LEN - 1));
                out_last_d   = (o_nxt_c == O_W'(N_OUT - 1));
            end
            ST_INP: begin
                addr_valid_d = 1'b1;
                addr_d       = inp_ptr_d;
                addr_kind_d  = AK_INP;
                ker_last_d   = (k_nxt_c == K_W'(KER_LEN - 1));
                out_last_d   = (o_nxt_c == O_W'(N_OUT - 1));
            end
            ST_OUT: begin
                addr_valid_d = 1'b1;
                addr_d       = ADDR_W'(OUT_BASE) + ADDR_W'(o_nxt_c);
                addr_kind_d  = AK_OUT;
                out_last_d   = (o_nxt_c == O_W'(N_OUT - 1));
            end
            default: begin
                addr_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            win_base_q   <= '0;
            inp_ptr_q    <= '0;
            addr_valid_q <= 1'b0;
            addr_q       <= '0;
            addr_kind_q  <= AK_KER;
            ker_last_q   <= 1'b0;
            out_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_base_q   <= win_base_d;
            inp_ptr_q    <= inp_ptr_d;
            addr_valid_q <= addr_valid_d;
            addr_q       <= addr_d;
            addr_kind_q  <= addr_kind_d;
            ker_last_q   <= ker_last_d;
            out_last_q   <= out_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign addr_valid = addr_valid_q;
    assign addr       = addr_q;
    assign addr_kind  = addr_kind_q;
    assign ker_last   = ker_last_q;
    assign out_last   = out_last_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
